// File: rtl/pipeline_types.sv
// Shared types for the data-cache responder: FSM states, default geometry and
// the latched request record.
package pipeline_types;

  localparam int DCACHE_ADDR_W     = 32;
  localparam int DCACHE_DATA_W     = 32;
  localparam int DCACHE_LINE_WORDS = 4;
  localparam int DCACHE_SETS       = 64;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOOKUP      = 3'd1,
    ST_MISS_REQ    = 3'd2,
    ST_REFILL      = 3'd3,
    ST_UNC_RD_REQ  = 3'd4,
    ST_UNC_RD_WAIT = 3'd5,
    ST_WR_REQ      = 3'd6
  } dcache_state_t;

  typedef struct packed {
    logic                       we;
    logic [DCACHE_ADDR_W-1:0]   addr;
    logic [DCACHE_DATA_W-1:0]   wdata;
    logic [DCACHE_DATA_W/8-1:0] wstrb;
    logic                       uncached;
  } dcache_req_t;

endpackage

// File: rtl/dcache_data_array.sv
// Valid/tag/data storage for the direct-mapped data cache: one combinational
// read port, one byte-strobed word write port with tag/valid set.
module dcache_data_array #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int TAG_W      = 22,
  parameter int IDX_W      = $clog2(SETS),
  parameter int WORD_W     = $clog2(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_index,
  input  logic [WORD_W-1:0]   rd_word,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [WORD_W-1:0]   wr_word,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                set_en,
  input  logic [TAG_W-1:0]    set_tag
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] data_r [SETS*LINE_WORDS];
  logic [TAG_W-1:0]  tag_r  [SETS];
  logic [SETS-1:0]   valid_r;

  assign rd_valid = valid_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_data  = data_r[{rd_index, rd_word}];

  // Byte-strobed word write into the data store
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          data_r[{wr_index, wr_word}][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Tag store is only meaningful under a set valid bit, so it needs no reset
  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_r[wr_index] <= set_tag;
    end
  end

  // Line valid bits, cleared asynchronously so a reset invalidates the whole cache
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
    end else if (set_en) begin
      valid_r[wr_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Data-cache responder: direct-mapped, write-through, no-write-allocate cache
// with an uncached bypass, in front of a burst read / single-beat write port.
module dcache_responder
  import pipeline_types::*;
#(
  parameter int ADDR_W     = DCACHE_ADDR_W,
  parameter int DATA_W     = DCACHE_DATA_W,
  parameter int LINE_WORDS = DCACHE_LINE_WORDS,
  parameter int SETS       = DCACHE_SETS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic                req_uncached,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_rd_req,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  output logic [7:0]          mem_rd_len,
  input  logic                mem_rd_ack,
  input  logic                mem_rd_valid,
  input  logic [DATA_W-1:0]   mem_rd_data,
  input  logic                mem_rd_last,
  output logic                mem_wr_req,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_wr_strb,
  input  logic                mem_wr_ack
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - WORD_W - OFF_W;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  dcache_state_t     state_r, state_s;
  dcache_req_t       req_q_r;
  logic [WORD_W-1:0] beat_cnt_r;
  logic [DATA_W-1:0] cap_r;
  logic              req_ready_r, resp_valid_r, mem_rd_req_r, mem_wr_req_r;
  logic [DATA_W-1:0] resp_rdata_r, mem_wr_data_r;
  logic [ADDR_W-1:0] mem_rd_addr_r, mem_wr_addr_r;
  logic [7:0]        mem_rd_len_r;
  logic [STRB_W-1:0] mem_wr_strb_r;

  logic              accept_s, beat_s, last_s, resp_fire_s, hit_s;
  logic [DATA_W-1:0] resp_data_s;
  logic [WORD_W-1:0] req_word_s;
  logic [IDX_W-1:0]  req_idx_s;
  logic [TAG_W-1:0]  req_tag_s;
  logic [ADDR_W-1:0] line_base_s;

  logic              arr_valid_s;
  logic [TAG_W-1:0]  arr_tag_s;
  logic [DATA_W-1:0] arr_data_s;
  logic              arr_wr_en_s, arr_set_en_s;
  logic [WORD_W-1:0] arr_wr_word_s;
  logic [DATA_W-1:0] arr_wr_data_s;
  logic [STRB_W-1:0] arr_wr_strb_s;

  // Last-beat flag is not trusted: the beat counter decides when the line is full
  logic unused_s;
  assign unused_s = ^{mem_rd_last, req_q_r.uncached};

  assign req_word_s  = req_q_r.addr[OFF_W +: WORD_W];
  assign req_idx_s   = req_q_r.addr[OFF_W+WORD_W +: IDX_W];
  assign req_tag_s   = req_q_r.addr[ADDR_W-1 -: TAG_W];
  assign line_base_s = {req_q_r.addr[ADDR_W-1:OFF_W+WORD_W], {(OFF_W+WORD_W){1'b0}}};
  assign hit_s       = arr_valid_s && (arr_tag_s == req_tag_s);

  dcache_data_array #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_idx_s),
    .rd_word  (req_word_s),
    .rd_valid (arr_valid_s),
    .rd_tag   (arr_tag_s),
    .rd_data  (arr_data_s),
    .wr_en    (arr_wr_en_s),
    .wr_index (req_idx_s),
    .wr_word  (arr_wr_word_s),
    .wr_data  (arr_wr_data_s),
    .wr_strb  (arr_wr_strb_s),
    .set_en   (arr_set_en_s),
    .set_tag  (req_tag_s)
  );

  // Next-state, response and array-write decode
  always_comb begin
    state_s       = state_r;
    accept_s      = 1'b0;
    beat_s        = 1'b0;
    last_s        = 1'b0;
    resp_fire_s   = 1'b0;
    resp_data_s   = '0;
    arr_wr_en_s   = 1'b0;
    arr_set_en_s  = 1'b0;
    arr_wr_word_s = req_word_s;
    arr_wr_data_s = req_q_r.wdata;
    arr_wr_strb_s = req_q_r.wstrb;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          accept_s = 1'b1;
          if (req_uncached) begin
            state_s = req_we ? ST_WR_REQ : ST_UNC_RD_REQ;
          end else begin
            state_s = ST_LOOKUP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (req_q_r.we) begin
          // Write-through: a hit merges the strobed bytes, a miss leaves the arrays alone
          arr_wr_en_s = hit_s;
          state_s     = ST_WR_REQ;
        end else if (hit_s) begin
          resp_fire_s = 1'b1;
          resp_data_s = arr_data_s;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        if (mem_rd_ack) begin
          beat_s  = mem_rd_valid;
          last_s  = mem_rd_valid && (beat_cnt_r == LAST_BEAT);
          state_s = last_s ? ST_IDLE : ST_REFILL;
        end else begin
          state_s = ST_MISS_REQ;
        end
      end
      ST_REFILL: begin
        beat_s  = mem_rd_valid;
        last_s  = mem_rd_valid && (beat_cnt_r == LAST_BEAT);
        state_s = last_s ? ST_IDLE : ST_REFILL;
      end
      ST_UNC_RD_REQ: begin
        if (mem_rd_ack && mem_rd_valid) begin
          resp_fire_s = 1'b1;
          resp_data_s = mem_rd_data;
          state_s     = ST_IDLE;
        end else if (mem_rd_ack) begin
          state_s = ST_UNC_RD_WAIT;
        end else begin
          state_s = ST_UNC_RD_REQ;
        end
      end
      ST_UNC_RD_WAIT: begin
        if (mem_rd_valid) begin
          resp_fire_s = 1'b1;
          resp_data_s = mem_rd_data;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_UNC_RD_WAIT;
        end
      end
      ST_WR_REQ: begin
        if (mem_wr_ack) begin
          resp_fire_s = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_WR_REQ;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (beat_s) begin
      arr_wr_en_s   = 1'b1;
      arr_wr_word_s = beat_cnt_r;
      arr_wr_data_s = mem_rd_data;
      arr_wr_strb_s = '1;
      arr_set_en_s  = last_s;
    end else begin
      arr_set_en_s = 1'b0;
    end
    // The requested word comes from the beat stream, either this beat or an earlier capture
    if (last_s) begin
      resp_fire_s = 1'b1;
      resp_data_s = (beat_cnt_r == req_word_s) ? mem_rd_data : cap_r;
    end else begin
      resp_fire_s = resp_fire_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered handshakes, request latch, memory-port fields and refill bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q_r       <= '0;
      req_ready_r   <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_rdata_r  <= '0;
      mem_rd_req_r  <= 1'b0;
      mem_rd_addr_r <= '0;
      mem_rd_len_r  <= 8'd0;
      mem_wr_req_r  <= 1'b0;
      mem_wr_addr_r <= '0;
      mem_wr_data_r <= '0;
      mem_wr_strb_r <= '0;
      beat_cnt_r    <= '0;
      cap_r         <= '0;
    end else begin
      req_ready_r  <= (state_s == ST_IDLE);
      resp_valid_r <= resp_fire_s;
      mem_rd_req_r <= (state_s == ST_MISS_REQ) || (state_s == ST_UNC_RD_REQ);
      mem_wr_req_r <= (state_s == ST_WR_REQ);
      if (resp_fire_s) begin
        resp_rdata_r <= resp_data_s;
      end
      if (accept_s) begin
        req_q_r <= '{we: req_we, addr: req_addr, wdata: req_wdata,
                     wstrb: req_wstrb, uncached: req_uncached};
        if (req_uncached) begin
          mem_rd_addr_r <= req_addr;
          mem_rd_len_r  <= 8'd0;
          mem_wr_addr_r <= req_addr;
          mem_wr_data_r <= req_wdata;
          mem_wr_strb_r <= req_wstrb;
        end
      end
      if (state_r == ST_LOOKUP) begin
        mem_rd_addr_r <= line_base_s;
        mem_rd_len_r  <= 8'(LINE_WORDS - 1);
        mem_wr_addr_r <= req_q_r.addr;
        mem_wr_data_r <= req_q_r.wdata;
        mem_wr_strb_r <= req_q_r.wstrb;
      end
      if ((state_r != ST_MISS_REQ) && (state_r != ST_REFILL)) begin
        beat_cnt_r <= '0;
      end else if (beat_s) begin
        beat_cnt_r <= beat_cnt_r + WORD_W'(1);
      end
      if (beat_s && (beat_cnt_r == req_word_s)) begin
        cap_r <= mem_rd_data;
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign resp_valid  = resp_valid_r;
  assign resp_rdata  = resp_rdata_r;
  assign mem_rd_req  = mem_rd_req_r;
  assign mem_rd_addr = mem_rd_addr_r;
  assign mem_rd_len  = mem_rd_len_r;
  assign mem_wr_req  = mem_wr_req_r;
  assign mem_wr_addr = mem_wr_addr_r;
  assign mem_wr_data = mem_wr_data_r;
  assign mem_wr_strb = mem_wr_strb_r;

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: directed accesses push expected
// responses; a monitor pops and compares each resp_valid pulse.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_uncached = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic [7:0]  mem_rd_len;
  logic [3:0]  mem_wr_strb;
  logic        mem_rd_ack = 1'b0, mem_rd_valid = 1'b0, mem_rd_last = 1'b0, mem_wr_ack = 1'b0;
  logic [31:0] mem_rd_data = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_hs   = 0;
  int wr_hs   = 0;

  typedef logic [31:0] line_t [4];
  typedef struct {
    logic [31:0] rdata;
    int          cyc;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  dcache_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_uncached(req_uncached),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_rd_last(mem_rd_last),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb), .mem_wr_ack(mem_wr_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_req && mem_rd_ack) rd_hs <= rd_hs + 1;
    if (mem_wr_req && mem_wr_ack) wr_hs <= wr_hs + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: got rdata 0x%08h expected no response", resp_rdata);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_rdata"}, resp_rdata, e.rdata);
          if (e.cyc >= 0) check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // Issue one request; push expected response (lat2 => exactly 2 cycles after accept)
  task automatic issue(input string name, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st, input bit unc,
                       input bit push, input logic [31:0] exp_rd, input bit lat2);
    int t = 0;
    int acc;
    exp_t e;
    while (req_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_wstrb = st; req_uncached = unc;
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_uncached = 1'b0;
    if (push) begin
      e.rdata = exp_rd; e.cyc = lat2 ? acc + 2 : -1; e.name = name;
      exp_q.push_back(e);
    end
  endtask

  // Serve a read burst; stop_at < nbeats abandons the burst before that beat
  task automatic serve_rd(input string name, input logic [31:0] exp_addr, input logic [7:0] exp_len,
                          input line_t beats, input int nbeats, input bit same_cycle,
                          input int ack_delay, input int stop_at);
    int t = 0;
    int i;
    while (mem_rd_req !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check({name, "_rd_req"}, 32'(mem_rd_req), 32'd1);
    check({name, "_rd_addr"}, mem_rd_addr, exp_addr);
    check({name, "_rd_len"}, 32'(mem_rd_len), 32'(exp_len));
    repeat (ack_delay) begin
      @(posedge clk); #1;
    end
    mem_rd_ack = 1'b1;
    if (same_cycle) begin
      mem_rd_valid = 1'b1; mem_rd_data = beats[0]; mem_rd_last = (nbeats == 1);
    end
    @(posedge clk); #1;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_last = 1'b0;
    i = same_cycle ? 1 : 0;
    while (i < nbeats && i != stop_at) begin
      mem_rd_valid = 1'b1; mem_rd_data = beats[i]; mem_rd_last = (i == nbeats - 1);
      @(posedge clk); #1;
      i++;
    end
    mem_rd_valid = 1'b0; mem_rd_last = 1'b0;
  endtask

  // Serve a write, acking in the first cycle the request is seen
  task automatic serve_wr(input string name, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data, input logic [3:0] exp_strb);
    int t = 0;
    while (mem_wr_req !== 1'b1 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check({name, "_wr_req"}, 32'(mem_wr_req), 32'd1);
    check({name, "_wr_addr"}, mem_wr_addr, exp_addr);
    check({name, "_wr_data"}, mem_wr_data, exp_data);
    check({name, "_wr_strb"}, 32'(mem_wr_strb), 32'(exp_strb));
    mem_wr_ack = 1'b1;
    @(posedge clk); #1;
    mem_wr_ack = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check({name, "_resp_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int r0, w0;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, w0;
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
    check("rst_mem_wr_req", 32'(mem_wr_req), 32'd0);
    check("rst_mem_rd_addr", mem_rd_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // 1: cold load misses and refills
    issue("cold_load", 1'b0, 32'h1000_0004, 32'd0, 4'd0, 1'b0, 1'b1, 32'h22, 1'b0);
    serve_rd("cold_load", 32'h1000_0000, 8'd3, '{32'h11, 32'h22, 32'h33, 32'h44}, 4, 1'b0, 1, 99);
    wait_resp("cold_load");

    // 2: hit, no memory traffic, 2-cycle latency
    r0 = rd_hs;
    issue("hit_load", 1'b0, 32'h1000_000C, 32'd0, 4'd0, 1'b0, 1'b1, 32'h44, 1'b1);
    wait_resp("hit_load");
    check("hit_no_mem_rd", 32'(rd_hs), 32'(r0));

    // 3: store hit merges low two bytes, then reload
    issue("store_hit", 1'b1, 32'h1000_0008, 32'hAABB_CCDD, 4'b0011, 1'b0, 1'b1, 32'd0, 1'b0);
    serve_wr("store_hit", 32'h1000_0008, 32'hAABB_CCDD, 4'b0011);
    wait_resp("store_hit");
    issue("merge_load", 1'b0, 32'h1000_0008, 32'd0, 4'd0, 1'b0, 1'b1, 32'h0000_CCDD, 1'b1);
    wait_resp("merge_load");

    // 5: uncached load ignores the cached copy; ack and data in the same cycle
    issue("unc_load", 1'b0, 32'h1000_0004, 32'd0, 4'd0, 1'b1, 1'b1, 32'h5555_AAAA, 1'b0);
    serve_rd("unc_load", 32'h1000_0004, 8'd0, '{32'h5555_AAAA, 32'd0, 32'd0, 32'd0}, 1, 1'b1, 0, 99);
    wait_resp("unc_load");
    issue("after_unc", 1'b0, 32'h1000_0004, 32'd0, 4'd0, 1'b0, 1'b1, 32'h22, 1'b1);
    wait_resp("after_unc");

    // Uncached store leaves the cached line untouched
    issue("unc_store", 1'b1, 32'h1000_000C, 32'h9999_9999, 4'hF, 1'b1, 1'b1, 32'd0, 1'b0);
    serve_wr("unc_store", 32'h1000_000C, 32'h9999_9999, 4'hF);
    wait_resp("unc_store");
    issue("after_unc_st", 1'b0, 32'h1000_000C, 32'd0, 4'd0, 1'b0, 1'b1, 32'h44, 1'b1);
    wait_resp("after_unc_st");

    // 4: store miss writes through without allocating; next load misses
    r0 = rd_hs; w0 = wr_hs;
    issue("store_miss", 1'b1, 32'h2000_0000, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'd0, 1'b0);
    serve_wr("store_miss", 32'h2000_0000, 32'h1234_5678, 4'hF);
    wait_resp("store_miss");
    check("store_miss_no_refill", 32'(rd_hs), 32'(r0));
    check("store_miss_one_write", 32'(wr_hs), 32'(w0 + 1));
    issue("miss_after_st", 1'b0, 32'h2000_0000, 32'd0, 4'd0, 1'b0, 1'b1, 32'hA0, 1'b0);
    serve_rd("miss_after_st", 32'h2000_0000, 8'd3, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 4, 1'b1, 0, 99);
    wait_resp("miss_after_st");
    issue("hit_word3", 1'b0, 32'h2000_000C, 32'd0, 4'd0, 1'b0, 1'b1, 32'hA3, 1'b1);
    wait_resp("hit_word3");

    // 6: reset during refill beat 2 abandons the access
    issue("rst_refill", 1'b0, 32'h3000_0014, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    serve_rd("rst_refill", 32'h3000_0010, 8'd3, '{32'hB0, 32'hB1, 32'hB2, 32'hB3}, 4, 1'b0, 0, 2);
    rst = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_resp_rdata", resp_rdata, 32'd0);
    check("midrst_mem_rd_req", 32'(mem_rd_req), 32'd0);
    check("midrst_mem_rd_addr", mem_rd_addr, 32'd0);
    check("midrst_mem_wr_addr", mem_wr_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    issue("reload_after_rst", 1'b0, 32'h3000_0014, 32'd0, 4'd0, 1'b0, 1'b1, 32'hC1, 1'b0);
    serve_rd("reload_after_rst", 32'h3000_0010, 8'd3, '{32'hC0, 32'hC1, 32'hC2, 32'hC3}, 4, 1'b0, 2, 99);
    wait_resp("reload_after_rst");
    issue("old_line_gone", 1'b0, 32'h2000_0004, 32'd0, 4'd0, 1'b0, 1'b1, 32'hD1, 1'b0);
    serve_rd("old_line_gone", 32'h2000_0000, 8'd3, '{32'hD0, 32'hD1, 32'hD2, 32'hD3}, 4, 1'b0, 0, 99);
    wait_resp("old_line_gone");

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
